// File: rtl/phyclocks_ctrl_if.sv
// Bundle of the PLL/PHY sequencing and speed-change signals of phyclocks_ctrl.
//   pll_locked  : PLL lock, asynchronous to refclk
//   pll_rst     : PLL reset, active high
//   phy_rst_n   : PHY reset, active low
//   speed_req   : one-cycle speed change strobe
//   speed_10m   : requested speed, valid with speed_req (1 = 10M)
//   speed_ack   : one-cycle pulse when the requested speed is in effect
//   clk_sel     : MAC clock mux select (0 = 25 MHz, 1 = 2.5 MHz)
//   clk_en      : MAC clock gate enable
//   ready       : high only while running with a stable clock
//   lock_lost   : one-cycle pulse on loss of an accepted lock
//   retry_count : PLL reset attempts since reset, saturating at 15
// The master side drives the PLL lock and speed requests; the slave side
// (the sequencer) drives everything else.
interface phyclocks_ctrl_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       phy_rst_n;
    logic       speed_req;
    logic       speed_10m;
    logic       speed_ack;
    logic       clk_sel;
    logic       clk_en;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_count;

    modport master (
        output pll_locked, speed_req, speed_10m,
        input  pll_rst, phy_rst_n, speed_ack, clk_sel, clk_en, ready,
               lock_lost, retry_count
    );

    modport slave (
        input  pll_locked, speed_req, speed_10m,
        output pll_rst, phy_rst_n, speed_ack, clk_sel, clk_en, ready,
               lock_lost, retry_count
    );
endinterface

// File: rtl/phyclocks_ctrl.sv
// Ethernet PHY clock PLL sequencer. Pulses the PLL reset, qualifies the
// synchronised lock, releases the PHY reset, and performs glitch-free
// 100M/10M MAC clock switchover with a request/acknowledge handshake.
// Lock loss after acceptance restarts the whole sequence automatically.
// Ports:
//   refclk : 50 MHz free-running clock, all logic runs on it
//   rst_n  : synchronous active-low reset
//   bus    : phyclocks_ctrl_if slave modport (PLL, PHY and speed signals)
module phyclocks_ctrl #(
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int LOCK_STABLE    = 1024,
    parameter int PHY_RST_CYCLES = 500000,
    parameter int GATE_CYCLES    = 8,
    parameter int CNT_W          = 20
) (
    input  logic             refclk,
    input  logic             rst_n,
    phyclocks_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_LOCK_STABLE,
        S_PHY_RESET,
        S_RUN,
        S_GATE_OFF,
        S_GATE_ON
    } state_t;

    // Counter reload values: a state with reload N-1 lasts exactly N cycles.
    localparam logic [CNT_W-1:0] LD_RST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_STABLE  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] LD_PHY     = CNT_W'(PHY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_GATE    = CNT_W'(GATE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lk_meta;
    logic             lk_s;
    logic             pll_rst_r;
    logic             phy_rst_n_r;
    logic             clk_en_r;
    logic             clk_sel_r;
    logic             ready_r;
    logic             speed_ack_r;
    logic             lock_lost_r;
    logic [3:0]       retry_r;
    logic             pending;
    logic             target;
    logic             sw_target;   // speed being switched to while gating
    logic             lock_drop;
    logic [3:0]       retry_inc;

    // Lock loss only matters once lock has been accepted.
    always_comb begin
        lock_drop = 1'b0;
        if (!lk_s && (state == S_PHY_RESET || state == S_RUN ||
                      state == S_GATE_OFF  || state == S_GATE_ON))
            lock_drop = 1'b1;
    end

    assign retry_inc = (retry_r == 4'hF) ? 4'hF : retry_r + 4'd1;

    // Two-flop synchroniser for the asynchronous lock input.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= bus.pll_locked;
            lk_s    <= lk_meta;
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state       <= S_RESET_PLL;
            cnt         <= LD_RST;
            pll_rst_r   <= 1'b1;
            phy_rst_n_r <= 1'b0;
            clk_en_r    <= 1'b0;
            clk_sel_r   <= 1'b0;
            ready_r     <= 1'b0;
            speed_ack_r <= 1'b0;
            lock_lost_r <= 1'b0;
            retry_r     <= 4'd0;
            pending     <= 1'b0;
        end else begin
            speed_ack_r <= 1'b0;
            lock_lost_r <= 1'b0;
            if (cnt != '0)
                cnt <= cnt - CNT_W'(1);

            if (lock_drop) begin
                state       <= S_RESET_PLL;
                cnt         <= LD_RST;
                pll_rst_r   <= 1'b1;
                phy_rst_n_r <= 1'b0;
                clk_en_r    <= 1'b0;
                ready_r     <= 1'b0;
                lock_lost_r <= 1'b1;
                retry_r     <= retry_inc;
                // An interrupted switch goes back to pending so it is
                // completed and acked after RUN is re-entered.
                if ((state == S_GATE_OFF || state == S_GATE_ON) && !pending) begin
                    pending <= 1'b1;
                    target  <= sw_target;
                end
            end else begin
                case (state)
                    S_RESET_PLL: begin
                        if (cnt == '0) begin
                            state     <= S_WAIT_LOCK;
                            cnt       <= LD_TIMEOUT;
                            pll_rst_r <= 1'b0;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (lk_s) begin
                            state <= S_LOCK_STABLE;
                            cnt   <= LD_STABLE;
                        end else if (cnt == '0) begin
                            state     <= S_RESET_PLL;
                            cnt       <= LD_RST;
                            pll_rst_r <= 1'b1;
                            retry_r   <= retry_inc;
                        end
                    end
                    S_LOCK_STABLE: begin
                        if (!lk_s) begin
                            state <= S_WAIT_LOCK;
                            cnt   <= LD_TIMEOUT;
                        end else if (cnt == '0) begin
                            state <= S_PHY_RESET;
                            cnt   <= LD_PHY;
                        end
                    end
                    S_PHY_RESET: begin
                        if (cnt == '0) begin
                            state       <= S_RUN;
                            phy_rst_n_r <= 1'b1;
                            clk_en_r    <= 1'b1;
                            ready_r     <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (pending) begin
                            pending <= 1'b0;
                            if (target == clk_sel_r) begin
                                speed_ack_r <= 1'b1;
                            end else begin
                                state     <= S_GATE_OFF;
                                cnt       <= LD_GATE;
                                clk_en_r  <= 1'b0;
                                ready_r   <= 1'b0;
                                sw_target <= target;
                            end
                        end
                    end
                    S_GATE_OFF: begin
                        if (cnt == '0) begin
                            state     <= S_GATE_ON;
                            cnt       <= LD_GATE;
                            clk_sel_r <= sw_target;
                        end
                    end
                    S_GATE_ON: begin
                        if (cnt == '0) begin
                            state       <= S_RUN;
                            clk_en_r    <= 1'b1;
                            ready_r     <= 1'b1;
                            speed_ack_r <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= S_RESET_PLL;
                        cnt       <= LD_RST;
                        pll_rst_r <= 1'b1;
                    end
                endcase
            end

            // Latest request wins, and always overrides a same-cycle clear.
            if (bus.speed_req) begin
                pending <= 1'b1;
                target  <= bus.speed_10m;
            end
        end
    end

    assign bus.pll_rst     = pll_rst_r;
    assign bus.phy_rst_n   = phy_rst_n_r;
    assign bus.clk_en      = clk_en_r;
    assign bus.clk_sel     = clk_sel_r;
    assign bus.ready       = ready_r;
    assign bus.speed_ack   = speed_ack_r;
    assign bus.lock_lost   = lock_lost_r;
    assign bus.retry_count = retry_r;

endmodule
